// File: rtl/gbm_path_sequencer.sv
// Purpose: sequences GBM step requests over N_PATHS x N_STEPS and collects the S_next results.
// Latency: one cycle from start to the first request; each return is registered once before out_*.
// Backpressure: z_ready waits on gbm_ready and the path's pending bit; ret_ready waits on the output register.
module gbm_path_sequencer #(
    parameter int WIDTH   = 32,
    parameter int QFRAC   = 16,
    parameter int N_PATHS = 8,
    parameter int N_STEPS = 16,
    localparam int PW     = (N_PATHS > 1) ? $clog2(N_PATHS) : 1,
    localparam int SW     = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] s0,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] sigma,
    input  logic [WIDTH-1:0] dt,
    input  logic             z_valid,
    output logic             z_ready,
    input  logic [WIDTH-1:0] z,
    output logic             gbm_valid,
    input  logic             gbm_ready,
    output logic [WIDTH-1:0] gbm_z,
    output logic [WIDTH-1:0] gbm_s,
    output logic [WIDTH-1:0] gbm_r,
    output logic [WIDTH-1:0] gbm_sigma,
    output logic [WIDTH-1:0] gbm_dt,
    input  logic             ret_valid,
    output logic             ret_ready,
    input  logic [WIDTH-1:0] ret_s_next,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    out_path,
    output logic [SW-1:0]    out_step,
    output logic [WIDTH-1:0] out_s,
    output logic             busy,
    output logic             done,
    output logic             err_nonpos
);

    // Reject parameter sets the pointer arithmetic cannot handle.
    if (QFRAC >= WIDTH || N_PATHS < 2 || N_PATHS > 64 ||
        (N_PATHS & (N_PATHS - 1)) != 0 || N_STEPS < 1) begin : g_param_check
        $error("gbm_path_sequencer: unsupported parameter set");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   s_mem_q [N_PATHS];
    logic [N_PATHS-1:0] pending_q, pending_d;
    logic [PW-1:0]      ip_path_q, ip_path_d, rp_path_q, rp_path_d;
    logic [SW-1:0]      ip_step_q, ip_step_d, rp_step_q, rp_step_d;
    logic [WIDTH-1:0]   r_q, sigma_q, dt_q;
    logic               last_ret_q, last_ret_d;
    logic               out_valid_q, out_valid_d;
    logic [PW-1:0]      out_path_q, out_path_d;
    logic [SW-1:0]      out_step_q, out_step_d;
    logic [WIDTH-1:0]   out_s_q, out_s_d;
    logic               err_q, err_d;

    logic               start_fire, iss_fire, ret_fire;
    logic               iss_last, ret_last, ret_nonpos;
    logic [WIDTH-1:0]   ret_clamped;

    assign start_fire  = (state_q == S_IDLE) && start;
    assign iss_fire    = z_valid && z_ready;
    assign ret_fire    = ret_valid && ret_ready;
    assign iss_last    = (ip_path_q == PW'(N_PATHS - 1)) && (ip_step_q == SW'(N_STEPS - 1));
    assign ret_last    = (rp_path_q == PW'(N_PATHS - 1)) && (rp_step_q == SW'(N_STEPS - 1));
    // A zero or negative price is meaningless downstream; clamp it and flag it.
    assign ret_nonpos  = ret_s_next[WIDTH-1] || (ret_s_next == '0);
    assign ret_clamped = ret_nonpos ? '0 : ret_s_next;

    // Sequencing FSM plus the handshake outputs that depend on it.
    always_comb begin
        state_d   = state_q;
        z_ready   = 1'b0;
        gbm_valid = 1'b0;
        ret_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                z_ready   = !pending_q[ip_path_q] && gbm_ready;
                gbm_valid = z_valid && !pending_q[ip_path_q];
                ret_ready = !out_valid_q || out_ready;
                if (z_valid && !pending_q[ip_path_q] && gbm_ready && iss_last) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                ret_ready = !out_valid_q || out_ready;
                if (last_ret_q && (!out_valid_q || out_ready)) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Issue/return pointers, pending scoreboard and the one-entry output register.
    always_comb begin
        pending_d   = pending_q;
        ip_path_d   = ip_path_q;
        ip_step_d   = ip_step_q;
        rp_path_d   = rp_path_q;
        rp_step_d   = rp_step_q;
        last_ret_d  = last_ret_q;
        out_valid_d = out_valid_q;
        out_path_d  = out_path_q;
        out_step_d  = out_step_q;
        out_s_d     = out_s_q;
        err_d       = err_q;
        if (start_fire) begin
            pending_d  = '0;
            ip_path_d  = '0;
            ip_step_d  = '0;
            rp_path_d  = '0;
            rp_step_d  = '0;
            last_ret_d = 1'b0;
            err_d      = 1'b0;
        end else begin
            if (ret_fire) begin
                pending_d[rp_path_q] = 1'b0;
                out_valid_d = 1'b1;
                out_path_d  = rp_path_q;
                out_step_d  = rp_step_q;
                out_s_d     = ret_clamped;
                if (ret_nonpos) err_d = 1'b1;
                if (ret_last) last_ret_d = 1'b1;
                if (rp_path_q == PW'(N_PATHS - 1)) begin
                    rp_path_d = '0;
                    rp_step_d = rp_step_q + 1'b1;
                end else begin
                    rp_path_d = rp_path_q + 1'b1;
                end
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end
            // Issue and return are always on different paths, so both updates can apply.
            if (iss_fire) begin
                pending_d[ip_path_q] = 1'b1;
                if (ip_path_q == PW'(N_PATHS - 1)) begin
                    ip_path_d = '0;
                    ip_step_d = ip_step_q + 1'b1;
                end else begin
                    ip_path_d = ip_path_q + 1'b1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Datapath registers: pointers, latched parameters and the per-path price array.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            ip_path_q   <= '0;
            ip_step_q   <= '0;
            rp_path_q   <= '0;
            rp_step_q   <= '0;
            last_ret_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_path_q  <= '0;
            out_step_q  <= '0;
            out_s_q     <= '0;
            err_q       <= 1'b0;
            r_q         <= '0;
            sigma_q     <= '0;
            dt_q        <= '0;
            for (int i = 0; i < N_PATHS; i++) s_mem_q[i] <= '0;
        end else begin
            pending_q   <= pending_d;
            ip_path_q   <= ip_path_d;
            ip_step_q   <= ip_step_d;
            rp_path_q   <= rp_path_d;
            rp_step_q   <= rp_step_d;
            last_ret_q  <= last_ret_d;
            out_valid_q <= out_valid_d;
            out_path_q  <= out_path_d;
            out_step_q  <= out_step_d;
            out_s_q     <= out_s_d;
            err_q       <= err_d;
            if (start_fire) begin
                r_q     <= r;
                sigma_q <= sigma;
                dt_q    <= dt;
                for (int i = 0; i < N_PATHS; i++) s_mem_q[i] <= s0;
            end else if (ret_fire) begin
                s_mem_q[rp_path_q] <= ret_clamped;
            end
        end
    end

    assign gbm_z      = z;
    assign gbm_s      = s_mem_q[ip_path_q];
    assign gbm_r      = r_q;
    assign gbm_sigma  = sigma_q;
    assign gbm_dt     = dt_q;
    assign out_valid  = out_valid_q;
    assign out_path   = out_path_q;
    assign out_step   = out_step_q;
    assign out_s      = out_s_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err_nonpos = err_q;

endmodule

// File: tb/tb_gbm_path_sequencer.sv
// Bench for gbm_path_sequencer with 4 paths x 3 steps and a behavioural GBM stub (S_next = S + 1.0).
// The stub has a programmable latency and can inject a -1.0 result on one chosen request.
// RNG valid is held high or toggled; downstream ready is driven by the scenario tasks.
module tb_gbm_path_sequencer;

    localparam int          NP  = 4;
    localparam int          NS  = 3;
    localparam logic [31:0] S0V = 32'h0064_0000;
    localparam logic [31:0] ONE = 32'h0001_0000;
    localparam logic [31:0] RV  = 32'h0000_0CCD;
    localparam logic [31:0] SGV = 32'h0000_3333;
    localparam logic [31:0] DTV = 32'h0000_0400;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] s0, r, sigma, dt;
    logic        z_valid, z_ready;
    logic [31:0] z;
    logic        gbm_valid, gbm_ready;
    logic [31:0] gbm_z, gbm_s, gbm_r, gbm_sigma, gbm_dt;
    logic        ret_valid, ret_ready;
    logic [31:0] ret_s_next;
    logic        out_valid, out_ready;
    logic [1:0]  out_path, out_step;
    logic [31:0] out_s;
    logic        busy, done, err_nonpos;

    int n_checks = 0;
    int n_fail   = 0;

    // Stub and monitor state.
    int          cyc = 0, lat = 5, bad_idx = -1, zmode = 1;
    int          n_iss = 0, n_z = 0, n_done = 0, n_zr = 0, hs_err = 0;
    logic        zv_t = 1'b0;
    logic [31:0] zcnt = 32'h0;
    logic [31:0] q_val[$];
    int          q_due[$];
    int          iss_edge[$];
    int          ret_edge[$];
    logic [1:0]  col_p[$];
    logic [1:0]  col_k[$];
    logic [31:0] col_s[$];

    always #5 clk = ~clk;

    gbm_path_sequencer #(.WIDTH(32), .QFRAC(16), .N_PATHS(NP), .N_STEPS(NS)) dut (
        .clk(clk), .rst(rst), .start(start),
        .s0(s0), .r(r), .sigma(sigma), .dt(dt),
        .z_valid(z_valid), .z_ready(z_ready), .z(z),
        .gbm_valid(gbm_valid), .gbm_ready(gbm_ready), .gbm_z(gbm_z), .gbm_s(gbm_s),
        .gbm_r(gbm_r), .gbm_sigma(gbm_sigma), .gbm_dt(gbm_dt),
        .ret_valid(ret_valid), .ret_ready(ret_ready), .ret_s_next(ret_s_next),
        .out_valid(out_valid), .out_ready(out_ready), .out_path(out_path),
        .out_step(out_step), .out_s(out_s),
        .busy(busy), .done(done), .err_nonpos(err_nonpos)
    );

    // Stub/monitor: record every handshake seen at the clock edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            q_val.delete();
            q_due.delete();
        end else begin
            if (ret_valid && ret_ready && q_val.size() != 0) begin
                void'(q_val.pop_front());
                void'(q_due.pop_front());
                ret_edge.push_back(cyc);
            end
            if (gbm_valid && gbm_ready) begin
                q_val.push_back((n_iss == bad_idx) ? 32'hFFFF_0000 : gbm_s + ONE);
                q_due.push_back(cyc + lat);
                iss_edge.push_back(cyc);
                n_iss = n_iss + 1;
                if (gbm_z !== z) hs_err = hs_err + 1;
            end
            if ((gbm_valid && gbm_ready) != (z_valid && z_ready)) hs_err = hs_err + 1;
            if (z_valid && z_ready) n_z = n_z + 1;
            if (busy && z_ready) n_zr = n_zr + 1;
            if (out_valid && out_ready) begin
                col_p.push_back(out_path);
                col_k.push_back(out_step);
                col_s.push_back(out_s);
            end
            if (done) n_done = n_done + 1;
        end
    end

    // Stub outputs and RNG stream, updated mid-cycle.
    always @(negedge clk) begin
        if (q_val.size() != 0 && q_due[0] <= cyc + 1) begin
            ret_valid  = 1'b1;
            ret_s_next = q_val[0];
        end else begin
            ret_valid  = 1'b0;
            ret_s_next = 32'h0;
        end
        zv_t    = ~zv_t;
        z_valid = (zmode == 1) || (zmode == 2 && zv_t);
        z       = zcnt;
        zcnt    = zcnt + 32'h1357;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        iss_edge.delete();
        ret_edge.delete();
        col_p.delete();
        col_k.delete();
        col_s.delete();
        n_iss = 0; n_z = 0; n_done = 0; n_zr = 0; hs_err = 0;
    endtask

    task automatic launch();
        clear_logs();
        s0 = S0V; r = RV; sigma = SGV; dt = DTV;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (n_done == 0 && k < budget) begin
            tick();
            k++;
        end
        n_checks++;
        if (n_done == 0) begin
            n_fail++;
            $display("FAIL %s_done: no done pulse within %0d cycles", name, budget);
        end
    endtask

    task automatic check_seq(input string name, input bit bad_p1);
        n_checks++;
        if (col_s.size() != NP * NS) begin
            n_fail++;
            $display("FAIL %s_count: got %0d outputs, want %0d", name, col_s.size(), NP * NS);
        end
        for (int i = 0; i < NP * NS && i < col_s.size(); i++) begin
            logic [1:0]  ep, ek;
            logic [31:0] es;
            ep = 2'(i % NP);
            ek = 2'(i / NP);
            es = S0V + ONE * (i / NP + 1);
            if (bad_p1 && ep == 2'd1) es = ONE * (i / NP);
            n_checks++;
            if (col_p[i] !== ep || col_k[i] !== ek || col_s[i] !== es) begin
                n_fail++;
                $display("FAIL %s_out[%0d]: got p%0d k%0d %h, want p%0d k%0d %h",
                         name, i, col_p[i], col_k[i], col_s[i], ep, ek, es);
            end
        end
    endtask

    task automatic check_common(input string name);
        n_checks++;
        if (n_done !== 1 || n_z !== NP * NS || hs_err !== 0) begin
            n_fail++;
            $display("FAIL %s_common: done=%0d z=%0d hs_err=%0d, want 1 %0d 0",
                     name, n_done, n_z, hs_err, NP * NS);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || err_nonpos !== 1'b0 ||
            gbm_valid !== 1'b0 || z_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b ov=%b err=%b gv=%b zr=%b, want all 0",
                     busy, done, out_valid, err_nonpos, gbm_valid, z_ready);
        end
    endtask

    task automatic test_basic();
        lat = 5; zmode = 1; out_ready = 1'b1;
        launch();
        wait_done("basic", 500);
        check_seq("basic", 1'b0);
        check_common("basic");
        n_checks++;
        if (gbm_r !== RV || gbm_sigma !== SGV || gbm_dt !== DTV || err_nonpos !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latch: r=%h sig=%h dt=%h err=%b busy=%b, want %h %h %h 0 0",
                     gbm_r, gbm_sigma, gbm_dt, err_nonpos, busy, RV, SGV, DTV);
        end
    endtask

    task automatic test_stall();
        lat = 10; zmode = 1; out_ready = 1'b1;
        launch();
        wait_done("stall", 800);
        check_seq("stall", 1'b0);
        check_common("stall");
        n_checks++;
        if (iss_edge.size() < 6 || ret_edge.size() < 2) begin
            n_fail++;
            $display("FAIL stall_log: issues=%0d returns=%0d, want >=6 >=2", iss_edge.size(), ret_edge.size());
        end else begin
            if (iss_edge[4] != ret_edge[0] + 1 || iss_edge[5] != ret_edge[1] + 1) begin
                n_fail++;
                $display("FAIL stall_reissue: p0s1@%0d p1s1@%0d, want %0d %0d",
                         iss_edge[4], iss_edge[5], ret_edge[0] + 1, ret_edge[1] + 1);
            end
        end
        n_checks++;
        if (n_zr != NP * NS) begin
            n_fail++;
            $display("FAIL stall_zready: z_ready high on %0d edges, want %0d", n_zr, NP * NS);
        end
        lat = 5;
    endtask

    task automatic test_backpressure();
        logic [1:0]  hp, hk;
        logic [31:0] hs;
        int          k;
        lat = 5; zmode = 1; out_ready = 1'b1;
        launch();
        repeat (8) tick();
        out_ready = 1'b0;
        k = 0;
        while (out_valid !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold_valid: out_valid=%b, want 1", out_valid);
        end
        hp = out_path; hk = out_step; hs = out_s;
        for (int c = 0; c < 20; c++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || ret_ready !== 1'b0 || out_path !== hp ||
                out_step !== hk || out_s !== hs) begin
                n_fail++;
                $display("FAIL bp_stable[%0d]: ov=%b rr=%b p%0d k%0d %h, want 1 0 p%0d k%0d %h",
                         c, out_valid, ret_ready, out_path, out_step, out_s, hp, hk, hs);
            end
        end
        out_ready = 1'b1;
        wait_done("bp", 500);
        check_seq("bp", 1'b0);
        check_common("bp");
    endtask

    task automatic test_nonpos();
        lat = 5; zmode = 1; out_ready = 1'b1; bad_idx = 1;
        launch();
        wait_done("nonpos", 500);
        check_seq("nonpos", 1'b1);
        repeat (3) tick();
        n_checks++;
        if (err_nonpos !== 1'b1) begin
            n_fail++;
            $display("FAIL nonpos_sticky: err_nonpos=%b, want 1", err_nonpos);
        end
        bad_idx = -1;
    endtask

    task automatic test_ztoggle();
        lat = 5; zmode = 2; out_ready = 1'b1;
        launch();
        n_checks++;
        if (err_nonpos !== 1'b0) begin
            n_fail++;
            $display("FAIL ztog_errclear: err_nonpos=%b after start, want 0", err_nonpos);
        end
        wait_done("ztog", 800);
        check_seq("ztog", 1'b0);
        check_common("ztog");
        zmode = 1;
    endtask

    task automatic test_start_ignored();
        lat = 5; zmode = 1; out_ready = 1'b1;
        launch();
        repeat (5) tick();
        s0 = 32'h00C8_0000; r = 32'h0000_1234; sigma = 32'h0000_0001; dt = 32'h0000_0002;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("startign", 500);
        check_seq("startign", 1'b0);
        check_common("startign");
        n_checks++;
        if (gbm_r !== RV || gbm_sigma !== SGV || gbm_dt !== DTV) begin
            n_fail++;
            $display("FAIL startign_latch: r=%h sig=%h dt=%h, want %h %h %h",
                     gbm_r, gbm_sigma, gbm_dt, RV, SGV, DTV);
        end
    endtask

    task automatic test_reset_midrun();
        lat = 5; zmode = 1; out_ready = 1'b1;
        launch();
        repeat (14) tick();
        rst = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || n_done !== 0) begin
            n_fail++;
            $display("FAIL midreset_state: busy=%b ov=%b done_cnt=%0d, want 0 0 0", busy, out_valid, n_done);
        end
        rst = 1'b0;
        tick();
        launch();
        wait_done("midreset", 500);
        check_seq("midreset", 1'b0);
        check_common("midreset");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; gbm_ready = 1'b1;
        s0 = 32'h0; r = 32'h0; sigma = 32'h0; dt = 32'h0;
        test_reset();
        test_basic();
        test_stall();
        test_backpressure();
        test_nonpos();
        test_ztoggle();
        test_start_ignored();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
